// File: rtl/chebyshev_pkg.sv
// Shared definitions for the Chebyshev evaluator: default widths,
// sequencer state encoding and a width helper used by the datapath trim.
package chebyshev_pkg;

  localparam int DEF_WORD_LENGTH  = 16;
  localparam int DEF_COEFF_LENGTH = 16;
  localparam int DEF_DEGREE       = 3;
  localparam int DEF_NUM_FUNC     = 4;

  // Never returns 0 so derived vector widths stay legal for trivial sizes.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  localparam int WIDENING = clog2(DEF_DEGREE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/chebyshev_sequencer.sv
// Horner-step controller: latches x, walks c_DEGREE..c_0 through the ROM
// and the mult/add datapath, then hands the accumulator downstream.
module chebyshev_sequencer
  import chebyshev_pkg::*;
#(
  parameter int WORD_LENGTH  = DEF_WORD_LENGTH,
  parameter int COEFF_LENGTH = DEF_COEFF_LENGTH,
  parameter int DEGREE       = DEF_DEGREE,
  parameter int NUM_FUNC     = DEF_NUM_FUNC,
  localparam int K_W    = clog2(DEGREE + 1),
  localparam int F_W    = clog2(NUM_FUNC),
  localparam int ADDR_W = F_W + K_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_LENGTH-1:0]  in_data,
  input  logic [F_W-1:0]          in_func,
  output logic                    coeff_rd_en,
  output logic [ADDR_W-1:0]       coeff_addr,
  input  logic [COEFF_LENGTH-1:0] coeff_data,
  output logic                    dp_issue,
  output logic [WORD_LENGTH-1:0]  dp_x,
  output logic [WORD_LENGTH-1:0]  dp_acc,
  output logic [COEFF_LENGTH-1:0] dp_coeff,
  input  logic                    dp_valid,
  input  logic [WORD_LENGTH-1:0]  dp_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_LENGTH-1:0]  out_data,
  output logic                    busy,
  output logic                    error
);

  state_t state, state_nx;

  logic [WORD_LENGTH-1:0] x_q;
  logic [WORD_LENGTH-1:0] acc_q;
  logic [K_W-1:0]         k_q;
  logic [F_W-1:0]         func_q;
  logic                   err_q;

  logic accept;
  logic step_done;
  logic spurious;

  assign accept    = (state == S_IDLE) && in_valid;
  assign step_done = (state == S_WAIT) && dp_valid;
  // A result outside WAIT means the datapath and sequencer disagree.
  assign spurious  = dp_valid && ((state == S_FETCH) ||
                                  (state == S_ISSUE) ||
                                  (state == S_DONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      x_q    <= '0;
      acc_q  <= '0;
      k_q    <= '0;
      func_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        x_q    <= in_data;
        func_q <= in_func;
        acc_q  <= '0;
        k_q    <= K_W'(DEGREE);
      end
      if (step_done) begin
        acc_q <= dp_result;
        if (k_q != '0) k_q <= k_q - K_W'(1);
      end
      if (spurious) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    coeff_rd_en = 1'b0;
    dp_issue    = 1'b0;
    out_valid   = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_FETCH;
      end
      S_FETCH: begin
        coeff_rd_en = 1'b1;
        state_nx    = S_ISSUE;
      end
      S_ISSUE: begin
        dp_issue = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (dp_valid)
          state_nx = (k_q == '0) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign coeff_addr = {func_q, k_q};
  assign dp_x       = x_q;
  assign dp_acc     = acc_q;
  assign dp_coeff   = coeff_data;
  assign out_data   = acc_q;
  assign busy       = (state != S_IDLE);
  assign error      = err_q;

endmodule

// File: tb/tb_chebyshev_sequencer.sv
// Directed + random bench for chebyshev_sequencer with a ROM model,
// a two-stage mult/add datapath and a Horner reference model.
module tb_chebyshev_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_func = '0;
  logic        coeff_rd_en;
  logic [3:0]  coeff_addr;
  logic [15:0] coeff_data = '0;
  logic        dp_issue;
  logic [15:0] dp_x, dp_acc, dp_coeff;
  logic        dp_valid;
  logic [15:0] dp_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy, error;

  chebyshev_sequencer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_func(in_func),
    .coeff_rd_en(coeff_rd_en), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data),
    .dp_issue(dp_issue), .dp_x(dp_x), .dp_acc(dp_acc),
    .dp_coeff(dp_coeff), .dp_valid(dp_valid), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  logic [15:0] rom [16];
  logic        p1_v = 1'b0, p2_v = 1'b0, spur = 1'b0;
  logic [15:0] p1_r = '0, p2_r = '0;
  int          cyc = 0;
  int          n_assert = 0, n_fail = 0;

  logic [15:0] acc_log[$];
  logic [3:0]  addr_log[$];
  int          acc_edges[$];
  int          hs_edges[$];
  logic [15:0] res_log[$];

  // ROM with one-cycle read latency; datapath result two edges after issue.
  always @(posedge clock) begin
    if (coeff_rd_en) coeff_data <= rom[coeff_addr];
    p1_v <= dp_issue;
    p1_r <= 16'(dp_acc * dp_x + dp_coeff);
    p2_v <= p1_v;
    p2_r <= p1_r;
  end
  assign dp_valid  = p2_v | spur;
  assign dp_result = p2_r;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (dp_issue) acc_log.push_back(dp_acc);
    if (coeff_rd_en) addr_log.push_back(coeff_addr);
    if (in_valid && in_ready) acc_edges.push_back(cyc + 1);
    if (out_valid && out_ready) begin
      hs_edges.push_back(cyc + 1);
      res_log.push_back(out_data);
    end
  end

  function automatic logic [15:0] horner(input logic [15:0] x,
                                         input logic [1:0] f);
    logic [15:0] a;
    logic [3:0]  idx;
    a = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = {f, 2'(k)};
      a = 16'(a * x + rom[idx]);
    end
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] x, input logic [1:0] f,
                      output int a);
    a = -1;
    in_valid = 1'b1;
    in_data  = x;
    in_func  = f;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        a = cyc + 1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("accept_seen", 32'(a >= 0), 32'd1);
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        d = cyc;
        break;
      end
      @(negedge clock);
    end
    check("done_seen", 32'(d >= 0), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int a, d, base, n;
    logic [15:0] x1, x2;
    logic [1:0]  f1, f2;

    foreach (rom[i]) rom[i] = 16'($urandom);
    rom[4'h3] = 16'd1; rom[4'h2] = 16'd2;
    rom[4'h1] = 16'd3; rom[4'h0] = 16'd4;
    rom[4'hB] = 16'd5; rom[4'hA] = 16'd0;
    rom[4'h9] = 16'd0; rom[4'h8] = 16'd7;

    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_strobes", {30'd0, dp_issue, coeff_rd_en}, 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_acc", 32'(dp_acc), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic evaluation, then hold the result under backpressure.
    acc_log.delete();
    send(16'd2, 2'd0, a);
    check("busy_run", 32'(busy), 32'd1);
    wait_done(d);
    check("latency", 32'(d - a), 32'd16);
    check("basic_out", 32'(out_data), 32'd26);
    check("acc_seq_n", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check("acc_seq", 32'(acc_log[i]), (i == 0) ? 32'd0 :
            (i == 1) ? 32'd1 : (i == 2) ? 32'd4 : 32'd11);
    n = acc_edges.size();
    in_valid = 1'b1;
    in_data  = 16'd7;
    in_func  = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'd26);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_no_accept", 32'(acc_edges.size()), 32'(n));

    // ROM addressing for table 2.
    addr_log.delete();
    send(16'd1, 2'd2, a);
    wait_done(d);
    check("rom_out", 32'(out_data), 32'd12);
    check("rom_addr_n", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check("rom_addr", 32'(addr_log[i]), 32'(11 - i));
    handshake();

    // Spurious datapath result while issuing.
    send(16'd2, 2'd0, a);
    for (int i = 0; i < 20 && !dp_issue; i++) @(negedge clock);
    check("issue_seen", 32'(dp_issue), 32'd1);
    spur = 1'b1;
    @(negedge clock);
    spur = 1'b0;
    check("spur_error", 32'(error), 32'd1);
    wait_done(d);
    check("spur_out", 32'(out_data), 32'd26);
    handshake();
    check("err_sticky", 32'(error), 32'd1);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("err_cleared", 32'(error), 32'd0);

    // Reset during the second WAIT; the late result must be dropped.
    base = acc_log.size();
    send(16'd2, 2'd0, a);
    for (int i = 0; i < 40 && acc_log.size() < base + 2; i++)
      @(negedge clock);
    check("second_issue", 32'(acc_log.size()), 32'(base + 2));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_acc", 32'(dp_acc), 32'd0);
    repeat (3) @(negedge clock);
    check("late_dp_err", 32'(error), 32'd0);
    check("late_dp_busy", 32'(busy), 32'd0);

    // Random operands against the Horner model.
    for (int t = 0; t < 6; t++) begin
      x1 = 16'($urandom);
      f1 = 2'($urandom);
      send(x1, f1, a);
      wait_done(d);
      check("rand_lat", 32'(d - a), 32'd16);
      check("rand_out", 32'(out_data), 32'(horner(x1, f1)));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      handshake();
    end

    // Back-to-back with in_valid held high.
    acc_edges.delete();
    hs_edges.delete();
    res_log.delete();
    x1 = 16'($urandom); f1 = 2'($urandom);
    x2 = 16'($urandom); f2 = 2'($urandom);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x1;
    in_func   = f1;
    for (int i = 0; i < 100 && acc_edges.size() < 1; i++)
      @(negedge clock);
    in_data = x2;
    in_func = f2;
    for (int i = 0; i < 100 && acc_edges.size() < 2; i++)
      @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && res_log.size() < 2; i++)
      @(negedge clock);
    out_ready = 1'b0;
    check("b2b_accepts", 32'(acc_edges.size()), 32'd2);
    check("b2b_results", 32'(res_log.size()), 32'd2);
    if (acc_edges.size() == 2 && res_log.size() == 2) begin
      check("b2b_period", 32'(acc_edges[1] - acc_edges[0]), 32'd18);
      check("b2b_after_hs", 32'(acc_edges[1] - hs_edges[0]), 32'd1);
      check("b2b_res0", 32'(res_log[0]), 32'(horner(x1, f1)));
      check("b2b_res1", 32'(res_log[1]), 32'(horner(x2, f2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
